// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: CPU-side master of the single-outstanding memory bus.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   req_*                 CPU load/store request (valid/ready, write, size, unsigned, addr, wdata)
//   resp_*                one-cycle response strobe with extended read data and error flag
//   mem_*                 bus side: valid/ready handshake, word address, lane data, byte strobes
module mem_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          write_q, uns_q;
    logic [1:0]    size_q, off_q;
    logic          mem_valid_q, resp_valid_q, resp_error_q;
    logic [31:0]   mem_addr_q, mem_wdata_q, resp_rdata_q;
    logic [3:0]    mem_wstrb_q;
    logic          bad;
    logic [3:0]    strb_d;
    logic [31:0]   wdata_d, shifted, rdata_d;
    assign req_ready  = state_q == IDLE;
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;
    always_comb begin
        bad     = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        strb_d  = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
                  req_size == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'b1111;
        wdata_d = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                  req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
        // halves are aligned, so shifting by 8*off selects the correct half-lane too
        shifted = mem_rdata >> {off_q, 3'b000};
        rdata_d = size_q == 2'b00 ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} :
                  size_q == 2'b01 ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : mem_rdata;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && bad) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b1;
                        resp_rdata_q <= '0;
                    end else if (req_valid) begin
                        state_q     <= BUS;
                        cnt_q       <= '0;
                        write_q     <= req_write;
                        uns_q       <= req_unsigned;
                        size_q      <= req_size;
                        off_q       <= req_addr[1:0];
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= {req_addr[31:2], 2'b00};
                        mem_wdata_q <= req_write ? wdata_d : '0;
                        mem_wstrb_q <= req_write ? strb_d : 4'b0000;
                    end
                end
                BUS: begin
                    // a completion in the final allowed cycle beats the timeout
                    if (mem_ready) begin
                        state_q      <= RESP;
                        mem_valid_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b0;
                        resp_rdata_q <= write_q ? '0 : rdata_d;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        state_q      <= RESP;
                        mem_valid_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
